// File: rtl/ui_entry_ctrl.sv
// ui_entry_ctrl: hex digit entry controller for a front-panel display.
// Collects key-press digits into a shift register, supports backspace,
// clear-on-next-digit arming, an address view and a stop-triggered clear.
// Optional build macro UI_ADDR_FOLLOW_EN: while in the address view the
// display tracks the addr input every cycle; undefined, disp holds.
module ui_entry_ctrl #(
  parameter int DIGITS = 6,
  parameter int ADDR_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  keys,
  input  logic                         b_bksp,
  input  logic                         b_load,
  input  logic                         b_inc,
  input  logic                         b_dec,
  input  logic                         stopped,
  input  logic                         clear_disp,
  input  logic [ADDR_W-1:0]            addr,
  output logic [4*DIGITS-1:0]          disp,
  output logic                         disp_valid,
  output logic [$clog2(DIGITS+1)-1:0]  n_digits,
  output logic                         ovf
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [1:0] ST_ENTRY = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_ADDR  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          stop_q;
  // Low for the first edge after reset release so a stopped level that is
  // already high at release is not mistaken for a fresh halt.
  logic          live_q;

  logic          stop_evt;
  logic          key_evt;
  logic [3:0]    digit;
  logic          cnt_full;

  // b_inc/b_dec only keep the address view; they carry no other action here.
`ifdef UI_ADDR_FOLLOW_EN
  logic          unused_ok;
  assign unused_ok = &{1'b0, b_inc, b_dec};
  logic [DW-1:0] addr_ext;
  // Zero-extend addr to the display width.
  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_W-1:0] = addr;
  end
`else
  logic          unused_ok;
  assign unused_ok = &{1'b0, b_inc, b_dec, addr};
`endif

  assign stop_evt = stopped & ~stop_q & live_q;
  assign key_evt  = |keys;
  assign cnt_full = (cnt_q == CW'(DIGITS));

  // Lowest-index set key wins when several are pressed together.
  always_comb begin
    digit = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (keys[i]) digit = 4'(i);
    end
  end

  // Event priority: stop > key > backspace > load; clear_disp arms on the side.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (stop_evt) begin
      disp_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ST_ENTRY;
    end else if (key_evt) begin
      if (state_q == ST_ARMED) begin
        disp_d = '0;
        disp_d[3:0] = digit;
        cnt_d  = CW'(1);
        ovf_d  = 1'b0;
      end else begin
        disp_d = {disp_q[DW-5:0], digit};
        cnt_d  = cnt_full ? cnt_q : cnt_q + CW'(1);
        ovf_d  = ovf_q | cnt_full;
      end
      state_d = ST_ENTRY;
    end else begin
      if (b_bksp) begin
        if (state_q == ST_ENTRY) begin
          disp_d = {4'h0, disp_q[DW-1:4]};
          cnt_d  = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        end
      end else if (b_load) begin
        state_d = ST_ADDR;
        cnt_d   = '0;
      end else if (state_q == ST_ADDR) begin
`ifdef UI_ADDR_FOLLOW_EN
        disp_d = addr_ext;
`endif
      end
      // Arming overrides the load's ADDR target but not its count clear.
      if (clear_disp) state_d = ST_ARMED;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      disp_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      stop_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      stop_q  <= stopped;
      live_q  <= 1'b1;
    end
  end

  assign disp       = disp_q;
  assign n_digits   = cnt_q;
  assign ovf        = ovf_q;
  assign disp_valid = !((state_q == ST_ARMED) && (cnt_q == '0));

endmodule
